// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// Entries pair a destination register with its result.
package wb_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency writeback results.
// The count register is what distinguishes full from empty.
import wb_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output logic [CW-1:0] count,
  output wb_entry_t head
);

  wb_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU stream vs buffered long-latency stream,
// one registered register-file write per cycle, bounded ALU priority.
import wb_pkg::*;

module writeback_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_DEFER = 3,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int DW = $clog2(MAX_DEFER + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              rf_write_en,
  output logic [REG_AW-1:0] rf_write_addr,
  output logic [XLEN-1:0]   rf_write_data,
  output logic [CW-1:0]     fifo_count
);

  logic full;
  logic empty;
  logic push;
  logic fifo_pri;
  logic alu_grant;
  logic fifo_grant;
  logic [DW-1:0] defer_cnt;
  wb_entry_t head;
  wb_entry_t lsu_entry;

  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

  assign fifo_pri   = !empty && (defer_cnt == DW'(MAX_DEFER));
  assign alu_grant  = !reset && alu_valid && !fifo_pri;
  assign fifo_grant = !reset && !alu_grant && !empty;
  assign alu_ready  = alu_grant;
  assign lsu_ready  = !reset && !full;

  // x0 results are acknowledged but never buffered.
  assign push = lsu_valid && lsu_ready && (lsu_rd != REG_ZERO);

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(lsu_entry),
    .pop       (fifo_grant),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (reset || empty || fifo_grant)
      defer_cnt <= '0;
    else if (alu_grant && (defer_cnt != DW'(MAX_DEFER)))
      defer_cnt <= defer_cnt + DW'(1);
  end

  // Address and data only move on a real write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
    end else if (alu_grant) begin
      rf_write_en <= (alu_rd != REG_ZERO);
      if (alu_rd != REG_ZERO) begin
        rf_write_addr <= alu_rd;
        rf_write_data <= alu_data;
      end
    end else if (fifo_grant) begin
      rf_write_en   <= 1'b1;
      rf_write_addr <= head.rd;
      rf_write_data <= head.data;
    end else begin
      rf_write_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios
// followed by randomized traffic against a queue-based model.
module tb_writeback_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic alu_valid, alu_ready;
  logic [4:0] alu_rd;
  logic [31:0] alu_data;
  logic lsu_valid, lsu_ready;
  logic [4:0] lsu_rd;
  logic [31:0] lsu_data;
  logic rf_write_en;
  logic [4:0] rf_write_addr;
  logic [31:0] rf_write_data;
  logic [2:0] fifo_count;

  int n_vec = 0;
  int n_err = 0;

  wb_entry_t q[$];
  int defer = 0;
  logic m_en = 1'b0;
  logic [4:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic s_alu_rdy, s_lsu_rdy;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .rf_write_en  (rf_write_en),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .fifo_count   (fifo_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic r, input logic av, input logic [4:0] ard,
                     input logic [31:0] ad, input logic lv,
                     input logic [4:0] lrd, input logic [31:0] ld);
    reset = r;
    alu_valid = av;
    alu_rd = ard;
    alu_data = ad;
    lsu_valid = lv;
    lsu_rd = lrd;
    lsu_data = ld;
  endtask

  // One clock: check readies before the edge, advance the model on
  // the edge, check the registered outputs just after it.
  task automatic cycle();
    logic e_ar, e_lr, pri;
    int sz;
    wb_entry_t e;
    #1;
    pri  = (q.size() != 0) && (defer == 3);
    e_ar = !reset && alu_valid && !pri;
    e_lr = !reset && (q.size() < 4);
    chk("alu_ready", alu_ready, e_ar);
    chk("lsu_ready", lsu_ready, e_lr);
    s_alu_rdy = alu_ready;
    s_lsu_rdy = lsu_ready;
    @(posedge clk);
    if (reset) begin
      q.delete();
      defer = 0;
      m_en = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      sz = q.size();
      if (e_ar) begin
        m_en = (alu_rd != 0);
        if (m_en) begin
          m_addr = alu_rd;
          m_data = alu_data;
        end
      end else if (sz > 0) begin
        e = q.pop_front();
        m_en = 1'b1;
        m_addr = e.rd;
        m_data = e.data;
      end else begin
        m_en = 1'b0;
      end
      if (sz == 0) defer = 0;
      else if (e_ar) defer = (defer < 3) ? defer + 1 : 3;
      else defer = 0;
      if (lsu_valid && e_lr && lsu_rd != 0)
        q.push_back('{rd: lsu_rd, data: lsu_data});
    end
    #1;
    chk("rf_write_en", rf_write_en, m_en);
    chk("rf_write_addr", rf_write_addr, m_addr);
    chk("rf_write_data", rf_write_data, m_data);
    chk("fifo_count", fifo_count, q.size());
    @(negedge clk);
  endtask

  initial begin
    int k;
    int i;
    logic av, lv;
    logic [4:0] ard, lrd;
    logic [31:0] ad, ld;

    drv(1, 1, 5'd9, 32'h9, 1, 5'd10, 32'hA);
    @(negedge clk);

    // Reset held with both sources valid.
    cycle();
    cycle();
    chk("rst_en", rf_write_en, 0);
    chk("rst_cnt", fifo_count, 0);
    drv(0, 1, 5'd9, 32'h9, 0, 5'd0, 32'h0);
    cycle();
    chk("first_alu_en", rf_write_en, 1);
    chk("first_alu_addr", rf_write_addr, 9);

    // ALU only.
    drv(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    cycle();
    chk("alu_same_cycle_rdy", s_alu_rdy, 1);
    chk("alu_addr", rf_write_addr, 5);
    chk("alu_data", rf_write_data, 32'hDEADBEEF);

    // FIFO drain: buffer two while ALU writes to x0, then drain.
    drv(0, 1, 5'd0, 32'h0, 1, 5'd3, 32'h11);
    cycle();
    drv(0, 1, 5'd0, 32'h0, 1, 5'd4, 32'h22);
    cycle();
    chk("drain_cnt2", fifo_count, 2);
    drv(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    cycle();
    chk("drain1_addr", rf_write_addr, 3);
    chk("drain1_data", rf_write_data, 32'h11);
    chk("drain_cnt1", fifo_count, 1);
    cycle();
    chk("drain2_addr", rf_write_addr, 4);
    chk("drain2_data", rf_write_data, 32'h22);
    chk("drain_cnt0", fifo_count, 0);

    // Starvation bound.
    drv(0, 1, 5'd1, 32'h100, 1, 5'd7, 32'h77);
    cycle();
    drv(0, 1, 5'd1, 32'h100, 0, 5'd0, 32'h0);
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk("starve_alu_rdy", s_alu_rdy, (j < 3) ? 1'b1 : 1'b0);
    end
    chk("starve_addr", rf_write_addr, 7);
    chk("starve_data", rf_write_data, 32'h77);
    drv(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    cycle();

    // Fill the FIFO while the ALU keeps winning.
    k = 0;
    for (i = 0; i < 40 && q.size() < 4; i++) begin
      drv(0, 1, 5'd2, 32'h200 + i, 1, 5'd8 + k[4:0], 32'h50 + k);
      cycle();
      if (s_lsu_rdy) k++;
    end
    chk("full_cnt", fifo_count, 4);
    drv(0, 1, 5'd2, 32'h300, 1, 5'd20, 32'h55);
    cycle();
    chk("full_lsu_rdy", s_lsu_rdy, 0);
    for (i = 0; i < 10 && !s_lsu_rdy; i++)
      cycle();
    if (!s_lsu_rdy) chk("held_push_timeout", 0, 1);
    drv(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    for (i = 0; i < 10 && q.size() > 0; i++)
      cycle();
    chk("empty_after_drain", fifo_count, 0);

    // x0 on both sides.
    drv(0, 1, 5'd0, 32'hBAD0, 1, 5'd0, 32'hBAD1);
    cycle();
    chk("x0_alu_rdy", s_alu_rdy, 1);
    chk("x0_lsu_rdy", s_lsu_rdy, 1);
    chk("x0_en", rf_write_en, 0);
    chk("x0_cnt", fifo_count, 0);

    // Reset with three buffered entries.
    for (int j = 0; j < 3; j++) begin
      drv(0, 1, 5'd1, 32'h400 + j, 1, 5'd11 + j[4:0], 32'h60 + j);
      cycle();
    end
    chk("pre_rst_cnt", fifo_count, 3);
    drv(1, 1, 5'd1, 32'h1, 1, 5'd12, 32'h12);
    cycle();
    chk("mid_rst_cnt", fifo_count, 0);
    chk("mid_rst_en", rf_write_en, 0);
    drv(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk("no_stale_write", rf_write_en, 0);
    end

    // Randomized traffic; sources hold until accepted.
    av = 0; lv = 0; ard = 0; lrd = 0; ad = 0; ld = 0;
    for (int j = 0; j < 400; j++) begin
      if (!(av && !s_alu_rdy)) begin
        av = ($urandom_range(0, 9) < 6);
        ard = 5'($urandom);
        ad = $urandom;
      end
      if (!(lv && !s_lsu_rdy)) begin
        lv = ($urandom_range(0, 9) < 5);
        lrd = 5'($urandom);
        ld = $urandom;
      end
      drv(($urandom_range(0, 49) == 0), av, ard, ad, lv, lrd, ld);
      cycle();
      if (reset) begin
        av = 0;
        lv = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
